booth_mul_4bit: RTL and testbench

//  Sequential signed radix-2 Booth multiplier; the consumer stage of the 4-bit add/sub unit.

---
 rtl/booth_mul_4bit.sv | 152 +++++++++++++++
 tb/tb_booth_mul_4bit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_4bit.sv
// Purpose: sequential signed radix-2 Booth multiplier (add/sub step, then arithmetic right shift per cycle).
// Latency: WIDTH cycles in CALC after the accept edge; done pulses for one cycle with product valid.
// Backpressure: none; start is accepted only when busy=0 (IDLE or DONE), otherwise ignored.
// Optional feature: define MUL_OVF_EN to add the ovf output (product does not fit in WIDTH signed bits).
module booth_mul_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
`ifdef MUL_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       m_q, m_d;      // sign-extended multiplicand
    logic [WIDTH:0]       acc_q, acc_d;  // one guard bit so -2^(WIDTH-1) never overflows
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef MUL_OVF_EN
    logic                 ovf_q, ovf_d;
`endif

    // Booth step datapath intermediates
    logic [WIDTH:0]       acc_sum;
    logic [WIDTH:0]       acc_sh;
    logic [WIDTH-1:0]     q_sh;
    logic [2*WIDTH-1:0]   prod_nxt;

    // Next-state logic: operand latch on accept, one Booth iteration per CALC cycle
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        product_d = product_q;
`ifdef MUL_OVF_EN
        ovf_d     = ovf_q;
`endif

        // Add/subtract M according to the {Q[0], q_1} pair; subtract is ~M with carry-in 1
        case ({q_q[0], q1_q})
            2'b01:   acc_sum = acc_q + m_q;
            2'b10:   acc_sum = acc_q + ~m_q + {{WIDTH{1'b0}}, 1'b1};
            default: acc_sum = acc_q;
        endcase
        // Arithmetic right shift of {ACC, Q, q_1}; ACC MSB is replicated
        acc_sh   = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        q_sh     = {acc_sum[0], q_q[WIDTH-1:1]};
        prod_nxt = {acc_sh[WIDTH-1:0], q_sh};

        case (state_q)
            IDLE, DONE: begin
                done_d = 1'b0;
                if (start) begin
                    state_d = CALC;
                    m_d     = {a[WIDTH-1], a};
                    q_d     = b;
                    q1_d    = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                q1_d  = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = prod_nxt;
`ifdef MUL_OVF_EN
                    ovf_d     = !((&prod_nxt[2*WIDTH-1:WIDTH-1]) ||
                                  (~|prod_nxt[2*WIDTH-1:WIDTH-1]));
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef MUL_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
`ifdef MUL_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
`ifdef MUL_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_booth_mul_4bit.sv
// Bench for booth_mul_4bit: directed vector table, hand sequences for hold/reset/back-to-back, full sweep.
module tb_booth_mul_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;
`ifdef MUL_OVF_EN
    logic       ovf;
`endif

    int nvec  = 0;
    int nfail = 0;

    booth_mul_4bit #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
`ifdef MUL_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic [7:0] exp_p;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Accept one operation at the next edge, then run until done (bounded).
    // hold=1 keeps start high with different operands through CALC, dropping it in the done cycle.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input bit hold,
                          output int busy_cnt, output bit ok);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        if (hold) begin
            a = ~ta; b = tb_v + 4'd3;
        end else begin
            start = 1'b0;
            a = 4'h0; b = 4'h0;
        end
        busy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int  bc;
        bit  ok;
        int  ndone;
        logic [7:0] exp8;

        vecs[0] = '{4'd3,  4'd5,  8'h0F, 1'b1};
        vecs[1] = '{4'h8,  4'h8,  8'h40, 1'b1};
        vecs[2] = '{4'h8,  4'd7,  8'hC8, 1'b1};
        vecs[3] = '{4'd7,  4'hF,  8'hF9, 1'b0};
        vecs[4] = '{4'd0,  4'hB,  8'h00, 1'b0};
        vecs[5] = '{4'd2,  4'd3,  8'h06, 1'b0};
        vecs[6] = '{4'hD,  4'd2,  8'hFA, 1'b0};
        vecs[7] = '{4'hF,  4'hF,  8'h01, 1'b0};
        vecs[8] = '{4'h8,  4'd1,  8'hF8, 1'b0};
        vecs[9] = '{4'd4,  4'd2,  8'h08, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset product", {24'd0, product}, 32'd0);
`ifdef MUL_OVF_EN
        chk("reset ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].va, vecs[i].vb, 1'b0, bc, ok);
            chk($sformatf("vec%0d done seen", i), {31'd0, ok}, 32'd1);
            chk($sformatf("vec%0d busy cycles", i), bc, 32'd4);
            chk($sformatf("vec%0d product", i), {24'd0, product}, {24'd0, vecs[i].exp_p});
`ifdef MUL_OVF_EN
            chk($sformatf("vec%0d ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
`endif
            @(negedge clk);
            chk($sformatf("vec%0d done width", i), {31'd0, done}, 32'd0);
            chk($sformatf("vec%0d product held", i), {24'd0, product}, {24'd0, vecs[i].exp_p});
        end

        // T4: start held with new operands during CALC is ignored
        run_op(4'd3, 4'd5, 1'b1, bc, ok);
        chk("T4 done seen", {31'd0, ok}, 32'd1);
        chk("T4 product", {24'd0, product}, 32'h0F);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("T4 extra dones", ndone, 32'd0);
        chk("T4 busy after", {31'd0, busy}, 32'd0);

        // T5: reset on 2nd CALC cycle discards the operation
        @(negedge clk);
        a = 4'd7; b = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("T5 busy calc1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("T5 busy", {31'd0, busy}, 32'd0);
        chk("T5 done", {31'd0, done}, 32'd0);
        chk("T5 product", {24'd0, product}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("T5 no done", ndone, 32'd0);

        // T6: back-to-back accept in the done cycle
        run_op(4'd2, 4'd3, 1'b0, bc, ok);
        chk("T6a done seen", {31'd0, ok}, 32'd1);
        chk("T6a product", {24'd0, product}, 32'h06);
        a = 4'hD; b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("T6 busy next", {31'd0, busy}, 32'd1);
        chk("T6 done low", {31'd0, done}, 32'd0);
        chk("T6 product kept", {24'd0, product}, 32'h06);
        ok = 1'b0;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        chk("T6b done seen", {31'd0, ok}, 32'd1);
        chk("T6b busy cycles", bc, 32'd4);
        chk("T6b product", {24'd0, product}, 32'hFA);

        // Full sweep against a signed multiply reference
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                logic [3:0] sa;
                logic [3:0] sb;
                sa = 4'(ia);
                sb = 4'(ib);
                exp8 = 8'($signed(sa) * $signed(sb));
                run_op(sa, sb, 1'b0, bc, ok);
                chk($sformatf("sweep %0h*%0h done", sa, sb), {31'd0, ok}, 32'd1);
                chk($sformatf("sweep %0h*%0h product", sa, sb), {24'd0, product}, {24'd0, exp8});
`ifdef MUL_OVF_EN
                chk($sformatf("sweep %0h*%0h ovf", sa, sb), {31'd0, ovf},
                    {31'd0, !((&exp8[7:3]) || (~|exp8[7:3]))});
`endif
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
